// File: rtl/ac_ctrl_seq_if.sv
// Control bus between the accumulator-machine sequencer and its datapath/stimulus.
// Slave modport is the sequencer side; master modport drives instruction and flag inputs.
interface ac_ctrl_seq_if;
  logic        start;
  logic [15:0] IR;
  logic [15:0] AC;
  logic        E;
  logic [15:0] DR;
  logic [9:0]  acCtl;
  logic        arLD;
  logic [1:0]  arSRC;
  logic        irLD;
  logic        pcINR;
  logic        pcLD;
  logic        drLD;
  logic        drINR;
  logic        memRD;
  logic        memWR;
  logic [1:0]  memSRC;
  logic        halted;
  logic [2:0]  sc;

  modport master (
    output start, IR, AC, E, DR,
    input  acCtl, arLD, arSRC, irLD, pcINR, pcLD, drLD, drINR,
           memRD, memWR, memSRC, halted, sc
  );

  modport slave (
    input  start, IR, AC, E, DR,
    output acCtl, arLD, arSRC, irLD, pcINR, pcLD, drLD, drINR,
           memRD, memWR, memSRC, halted, sc
  );
endinterface

// File: rtl/ac_ctrl_seq.sv
// Instruction sequencer for a 16-bit accumulator machine: fetch, decode, execute over T0..T6.
// Define ACSEQ_INDIRECT_EN to enable indirect addressing for memory-reference instructions.
module ac_ctrl_seq (
    input logic         CLK,
    input logic         RST_N,
    ac_ctrl_seq_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_i;
    logic [2:0]  w_d;
    logic [11:0] w_b;
    logic [9:0]  w_acCtl;
    logic        w_arLD;
    logic [1:0]  w_arSRC;
    logic        w_irLD;
    logic        w_pcINR;
    logic        w_pcLD;
    logic        w_drLD;
    logic        w_drINR;
    logic        w_memRD;
    logic        w_memWR;
    logic [1:0]  w_memSRC;
    logic        w_halted;
    logic [2:0]  w_sc;

    assign w_i = bus.IR[15];
    assign w_d = bus.IR[14:12];
    assign w_b = bus.IR[11:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_acCtl  = '0;
        w_arLD   = 1'b0;
        w_arSRC  = 2'd0;
        w_irLD   = 1'b0;
        w_pcINR  = 1'b0;
        w_pcLD   = 1'b0;
        w_drLD   = 1'b0;
        w_drINR  = 1'b0;
        w_memRD  = 1'b0;
        w_memWR  = 1'b0;
        w_memSRC = 2'd0;
        w_halted = 1'b0;
        w_sc     = 3'd0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_T0;
            end
            S_HALT: begin
                w_halted = 1'b1;
                if (bus.start) w_next = S_T0;
            end
            S_T0: begin
                w_sc    = 3'd0;
                w_arLD  = 1'b1;
                w_arSRC = 2'd0;
                w_next  = S_T1;
            end
            S_T1: begin
                w_sc    = 3'd1;
                w_memRD = 1'b1;
                w_irLD  = 1'b1;
                w_pcINR = 1'b1;
                w_next  = S_T2;
            end
            S_T2: begin
                w_sc    = 3'd2;
                w_arLD  = 1'b1;
                w_arSRC = 2'd1;
                w_next  = S_T3;
            end
            S_T3: begin
                w_sc = 3'd3;
                if (w_d == 3'd7) begin
                    w_next = S_T0;
                    if (!w_i) begin
                        // Register-reference: every set micro-op bit fires in the same step
                        w_acCtl[9] = w_b[11];
                        w_acCtl[4] = w_b[10];
                        w_acCtl[3] = w_b[9];
                        w_acCtl[2] = w_b[8];
                        w_acCtl[1] = w_b[7];
                        w_acCtl[0] = w_b[6];
                        w_acCtl[7] = w_b[5];
                        w_pcINR    = (w_b[4] & ~bus.AC[15]) | (w_b[3] & bus.AC[15]) |
                                     (w_b[2] & (bus.AC == 16'h0000)) | (w_b[1] & ~bus.E);
                        if (w_b[0]) w_next = S_HALT;
                    end
                end else begin
`ifdef ACSEQ_INDIRECT_EN
                    if (w_i) begin
                        w_memRD = 1'b1;
                        w_arLD  = 1'b1;
                        w_arSRC = 2'd2;
                    end
`endif
                    w_next = S_T4;
                end
            end
            S_T4: begin
                w_sc   = 3'd4;
                w_next = S_T0;
                case (w_d)
                    3'd0, 3'd1, 3'd2, 3'd6: begin
                        w_memRD = 1'b1;
                        w_drLD  = 1'b1;
                        w_next  = S_T5;
                    end
                    3'd3: begin
                        w_memWR  = 1'b1;
                        w_memSRC = 2'd0;
                    end
                    3'd4: w_pcLD = 1'b1;
                    3'd5: begin
                        w_memWR  = 1'b1;
                        w_memSRC = 2'd1;
                        w_arLD   = 1'b1;
                        w_arSRC  = 2'd3;
                        w_next   = S_T5;
                    end
                    default: w_next = S_T0;
                endcase
            end
            S_T5: begin
                w_sc   = 3'd5;
                w_next = S_T0;
                case (w_d)
                    3'd0: w_acCtl[6] = 1'b1;
                    3'd1: w_acCtl[5] = 1'b1;
                    3'd2: w_acCtl[8] = 1'b1;
                    3'd5: w_pcLD     = 1'b1;
                    3'd6: begin
                        w_drINR = 1'b1;
                        w_next  = S_T6;
                    end
                    default: w_next = S_T0;
                endcase
            end
            S_T6: begin
                // DR already holds the incremented value here
                w_sc     = 3'd6;
                w_memWR  = 1'b1;
                w_memSRC = 2'd2;
                w_pcINR  = (bus.DR == 16'h0000);
                w_next   = S_T0;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.acCtl  = w_acCtl;
    assign bus.arLD   = w_arLD;
    assign bus.arSRC  = w_arSRC;
    assign bus.irLD   = w_irLD;
    assign bus.pcINR  = w_pcINR;
    assign bus.pcLD   = w_pcLD;
    assign bus.drLD   = w_drLD;
    assign bus.drINR  = w_drINR;
    assign bus.memRD  = w_memRD;
    assign bus.memWR  = w_memWR;
    assign bus.memSRC = w_memSRC;
    assign bus.halted = w_halted;
    assign bus.sc     = w_sc;

endmodule

// File: tb/tb_ac_ctrl_seq.sv
// Scoreboard bench for ac_ctrl_seq: expected output vectors are queued per step and compared on sampling.
module tb_ac_ctrl_seq;

    logic CLK = 1'b0;
    logic RST_N;
    int unsigned r_checks = 0;
    int unsigned r_fails  = 0;
    logic [25:0] r_sb[$];

    ac_ctrl_seq_if u_if ();

    ac_ctrl_seq u_dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (u_if.slave)
    );

    always #5 CLK = ~CLK;

    logic [25:0] w_obs;
    assign w_obs = {u_if.sc, u_if.halted, u_if.acCtl, u_if.arLD, u_if.arSRC, u_if.irLD,
                    u_if.pcINR, u_if.pcLD, u_if.drLD, u_if.drINR, u_if.memRD, u_if.memWR,
                    u_if.memSRC};

    function automatic logic [25:0] ev(input logic [2:0] sc, input logic hlt,
                                       input logic [9:0] ac, input logic arld,
                                       input logic [1:0] arsrc, input logic irld,
                                       input logic pcinr, input logic pcld, input logic drld,
                                       input logic drinr, input logic memrd, input logic memwr,
                                       input logic [1:0] memsrc);
        return {sc, hlt, ac, arld, arsrc, irld, pcinr, pcld, drld, drinr, memrd, memwr, memsrc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_fails++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_now(input string tag, input logic [25:0] e);
        logic [25:0] exp_v;
        r_sb.push_back(e);
        #1;
        exp_v = r_sb.pop_front();
        chk(tag, {6'd0, w_obs}, {6'd0, exp_v});
    endtask

    task automatic step(input string tag, input logic [25:0] e);
        r_sb.push_back(e);
        #2;
        chk(tag, {6'd0, w_obs}, {6'd0, r_sb.pop_front()});
        @(negedge CLK);
    endtask

    logic [25:0] IDLE, T0E, T1E, T2E, T3Z, T4RD, HALTE;

    task automatic fetch(input logic [15:0] ir);
        u_if.IR = ir;
        step($sformatf("T0_%h", ir), T0E);
        step($sformatf("T1_%h", ir), T1E);
        step($sformatf("T2_%h", ir), T2E);
    endtask

    initial begin
        IDLE  = ev(3'd0, 1'b0, 10'h000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        T0E   = ev(3'd0, 1'b0, 10'h000, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        T1E   = ev(3'd1, 1'b0, 10'h000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        T2E   = ev(3'd2, 1'b0, 10'h000, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        T3Z   = ev(3'd3, 1'b0, 10'h000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        T4RD  = ev(3'd4, 1'b0, 10'h000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        HALTE = ev(3'd0, 1'b1, 10'h000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        RST_N = 1'b0;
        u_if.start = 1'b1;
        u_if.IR = 16'h0000;
        u_if.AC = 16'h0000;
        u_if.E  = 1'b0;
        u_if.DR = 16'h0000;
        chk_now("reset", IDLE);

        @(negedge CLK);
        RST_N = 1'b1;
        u_if.start = 1'b0;
        step("idle_hold", IDLE);
        u_if.start = 1'b1;
        step("idle_start", IDLE);
        u_if.start = 1'b0;

        // Register-reference group
        fetch(16'h7800);
        step("T3_CLA", ev(3'd3, 1'b0, 10'h200, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        u_if.AC = 16'h0000;
        fetch(16'h7004);
        step("T3_SZA_zero", ev(3'd3, 1'b0, 10'h000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        u_if.AC = 16'h0001;
        fetch(16'h7004);
        step("T3_SZA_nz", T3Z);
        u_if.AC = 16'h8000;
        fetch(16'h7008);
        step("T3_SNA_neg", ev(3'd3, 1'b0, 10'h000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        fetch(16'h7010);
        step("T3_SPA_neg", T3Z);
        u_if.E = 1'b0;
        fetch(16'h7002);
        step("T3_SZE_0", ev(3'd3, 1'b0, 10'h000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        u_if.E = 1'b1;
        fetch(16'h7002);
        step("T3_SZE_1", T3Z);
        u_if.AC = 16'h0000;
        fetch(16'h7FE0);
        step("T3_multi", ev(3'd3, 1'b0, 10'h29F, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));

        // Memory-reference group
        fetch(16'h1123);
        step("T3_ADD", T3Z);
        step("T4_ADD", T4RD);
        step("T5_ADD", ev(3'd5, 1'b0, 10'h020, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        fetch(16'h0123);
        step("T3_AND", T3Z);
        step("T4_AND", T4RD);
        step("T5_AND", ev(3'd5, 1'b0, 10'h040, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        fetch(16'h2123);
        step("T3_LDA", T3Z);
        step("T4_LDA", T4RD);
        step("T5_LDA", ev(3'd5, 1'b0, 10'h100, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        fetch(16'h3010);
        step("T3_STA", T3Z);
        step("T4_STA", ev(3'd4, 1'b0, 10'h000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
        fetch(16'h4010);
        step("T3_BUN", T3Z);
        step("T4_BUN", ev(3'd4, 1'b0, 10'h000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        fetch(16'h5010);
        step("T3_BSA", T3Z);
        step("T4_BSA", ev(3'd4, 1'b0, 10'h000, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1));
        step("T5_BSA", ev(3'd5, 1'b0, 10'h000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));

        fetch(16'h6050);
        step("T3_ISZ", T3Z);
        step("T4_ISZ", T4RD);
        u_if.DR = 16'hFFFF;
        step("T5_ISZ", ev(3'd5, 1'b0, 10'h000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));
        u_if.DR = 16'h0000;
        step("T6_ISZ_zero", ev(3'd6, 1'b0, 10'h000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2));
        fetch(16'h6050);
        step("T3_ISZ2", T3Z);
        step("T4_ISZ2", T4RD);
        u_if.DR = 16'h0004;
        step("T5_ISZ2", ev(3'd5, 1'b0, 10'h000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0));
        u_if.DR = 16'h0005;
        step("T6_ISZ_nz", ev(3'd6, 1'b0, 10'h000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2));

        fetch(16'h9010);
`ifdef ACSEQ_INDIRECT_EN
        step("T3_ind", ev(3'd3, 1'b0, 10'h000, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
`else
        step("T3_ind", T3Z);
`endif
        step("T4_ind", T4RD);
        step("T5_ind", ev(3'd5, 1'b0, 10'h020, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));

        fetch(16'hF800);
        step("T3_io", T3Z);

        // Halt, restart, then reset during a store
        fetch(16'h7001);
        step("T3_HLT", T3Z);
        step("halt_0", HALTE);
        step("halt_1", HALTE);
        u_if.start = 1'b1;
        step("halt_start", HALTE);
        u_if.start = 1'b0;
        fetch(16'h3010);
        step("T3_STA_rst", T3Z);
        @(posedge CLK);
        #1 RST_N = 1'b0;
        chk_now("rst_T4", IDLE);
        @(negedge CLK);
        RST_N = 1'b1;
        step("post_rst_0", IDLE);
        step("post_rst_1", IDLE);
        step("post_rst_2", IDLE);

        chk("sb_empty", r_sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_fails);
        $finish;
    end

endmodule
